// File: rtl/ifetch.sv
// Instruction fetch unit: PC register, credit-limited request/grant fetch to imem,
// in-order response tracking with stale-response dropping, and a small output FIFO.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o
);

  // DEPTH is 2 or 4, so ring pointers wrap naturally at their bit width.
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } fifo_entry_t;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] pa_rd_q, pa_rd_d, pa_wr_q, pa_wr_d;

  fifo_entry_t   fifo_q      [DEPTH];
  logic [31:0]   pend_addr_q [DEPTH];

  logic          pop, rsp, push, grant, have_credit;
  logic [CW:0]   occ;
  logic          jump_lsb_unused;

  assign jump_lsb_unused = ^jump_addr_i[1:0];

  assign inst_valid_o = (count_q != '0);
  assign inst_o       = inst_valid_o ? fifo_q[rd_ptr_q].inst : NOP;
  assign inst_addr_o  = inst_valid_o ? fifo_q[rd_ptr_q].addr : 32'h0;

  assign pop = inst_valid_o && inst_ready_i;
  // A response with nothing pending is a protocol error and is ignored.
  assign rsp = imem_rvalid_i && (inflight_q != '0);
  assign push = rsp && (drop_q == '0) && !jump_flag_i;

  // Credit: a slot is free if buffered + in-flight leaves room, counting this cycle's pop.
  assign occ = {1'b0, count_q} + {1'b0, inflight_q};
  assign have_credit = (occ < DEPTH_W) || (pop && (occ == DEPTH_W));

  // Gated by reset so no request is presented while the block is held in reset.
  assign imem_req_o  = rst && have_credit && !jump_flag_i;
  assign imem_addr_o = pc_q;
  assign grant       = imem_req_o && imem_gnt_i;

  // NOTE: every variable gets a default at the top of the block, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    pc_d       = pc_q;
    count_d    = count_q;
    inflight_d = inflight_q + CW'(grant) - CW'(rsp);
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    pa_rd_d    = pa_rd_q;
    pa_wr_d    = pa_wr_q;

    if (grant) begin
      pc_d    = pc_q + 32'd4;
      pa_wr_d = pa_wr_q + PW'(1);
    end
    if (rsp) begin
      pa_rd_d = pa_rd_q + PW'(1);
    end

    if (jump_flag_i) begin
      // Everything still outstanding is stale; the response landing now is discarded too.
      pc_d     = {jump_addr_i[31:2], 2'b00};
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      drop_d   = inflight_q - CW'(rsp);
    end else begin
      if (rsp && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      pa_rd_q    <= '0;
      pa_wr_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      pa_rd_q    <= pa_rd_d;
      pa_wr_q    <= pa_wr_d;
    end
  end

  // NOTE: storage arrays are not reset; their contents are only observed through
  // entries that count/inflight mark as live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{addr: pend_addr_q[pa_rd_q], inst: imem_rdata_i};
    end
    if (grant) begin
      pend_addr_q[pa_wr_q] <= pc_q;
    end
  end

  a_drop_le_inflight: assert property (@(posedge clk) disable iff (!rst)
    drop_q <= inflight_q);
  a_credit_bound: assert property (@(posedge clk) disable iff (!rst)
    occ <= DEPTH_W);
  a_no_req_on_jump: assert property (@(posedge clk) disable iff (!rst)
    jump_flag_i |-> !imem_req_o);

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: in-order latency-programmable memory model, scoreboard of the expected
// {addr, inst} stream derived from the redirect history, directed timing checks plus random run.
module tb_ifetch;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int          D   = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;

  ifetch #(.RESET_PC(RPC), .DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .jump_flag_i  (jump_flag_i),
    .jump_addr_i  (jump_addr_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  // ---------------- memory model: in-order, fixed latency per request ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t mem_q[$];
  int    cyc     = 0;
  int    lat     = 1;
  int    gnt_pct = 100;
  bit    spur_en = 1'b0;

  always begin
    @(posedge clk);
    cyc++;
    #1;
    imem_gnt_i = ($urandom_range(0, 99) < gnt_pct);
    if (!rst) begin
      mem_q.delete();
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'h0;
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else if (spur_en && mem_q.size() == 0 && $urandom_range(0, 99) < 5) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'hDEAD_BEEF;
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    @(negedge clk);
    if (rst && imem_req_o && imem_gnt_i) mem_q.push_back('{addr: imem_addr_o, due: cyc + lat});
  end

  // ---------------- scoreboard: expected output stream since last redirect ----------------
  logic [63:0] exp_q[$];
  logic [31:0] exp_next;
  bit          hold;
  logic [31:0] hold_addr, hold_inst;

  task automatic refill(input logic [31:0] start);
    exp_q.delete();
    exp_next = start;
    repeat (8) begin
      exp_q.push_back({exp_next, mem_word(exp_next)});
      exp_next += 32'd4;
    end
  endtask

  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst) begin
      refill(RPC);
      hold = 1'b0;
    end else begin
      if (hold) begin
        check1("hold_valid", inst_valid_o, 1'b1);
        check("hold_addr", inst_addr_o, hold_addr);
        check("hold_inst", inst_o, hold_inst);
      end
      if (inst_valid_o && inst_ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: got addr %h, expected no output", inst_addr_o);
        end else begin
          e = exp_q.pop_front();
          check("out_addr", inst_addr_o, e[63:32]);
          check("out_inst", inst_o, e[31:0]);
          exp_q.push_back({exp_next, mem_word(exp_next)});
          exp_next += 32'd4;
        end
      end else if (!inst_valid_o) begin
        check("idle_inst", inst_o, NOP);
        check("idle_addr", inst_addr_o, 32'h0);
      end
      hold      = inst_valid_o && !inst_ready_i && !jump_flag_i;
      hold_addr = inst_addr_o;
      hold_inst = inst_o;
      if (jump_flag_i) refill({jump_addr_i[31:2], 2'b00});
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic int inflight_est();
    return mem_q.size() + (imem_rvalid_i ? 1 : 0);
  endfunction

  // mode 0: two fetches outstanding; mode 1: response, valid head and pop all this cycle
  task automatic wait_cond(input int mode, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      if (mode == 0) found = (inflight_est() == 2);
      else           found = imem_rvalid_i && inst_valid_o && inst_ready_i;
      if (!found) tick();
    end
    check1(name, found, 1'b1);
  endtask

  task automatic do_jump(input logic [31:0] tgt, input bit chk_req);
    jump_flag_i = 1'b1;
    jump_addr_i = tgt;
    tick();
    jump_flag_i = 1'b0;
    @(negedge clk);
    check1("jump_j1_valid", inst_valid_o, 1'b0);
    if (chk_req) begin
      check1("jump_j1_req", imem_req_o, 1'b1);
      check("jump_j1_addr", imem_addr_o, tgt & 32'hFFFF_FFFC);
    end
    tick();
    @(negedge clk);
    check1("jump_j2_valid", inst_valid_o, 1'b0);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_req"}, imem_req_o, 1'b0);
    check({tag, "_addr"}, imem_addr_o, RPC);
    check1({tag, "_valid"}, inst_valid_o, 1'b0);
    check({tag, "_inst"}, inst_o, NOP);
    check({tag, "_iaddr"}, inst_addr_o, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b0;
    jump_flag_i  = 1'b0;
    jump_addr_i  = 32'h0;
    inst_ready_i = 1'b0;
    tick();
    tick();
    check_reset_outputs("rst");

    // Release mid-cycle: first cycle requests RESET_PC, data valid two cycles later.
    rst = 1'b1;
    #1;
    check1("c0_req", imem_req_o, 1'b1);
    check("c0_addr", imem_addr_o, RPC);
    check1("c0_valid", inst_valid_o, 1'b0);
    tick();
    @(negedge clk);
    check1("c1_valid", inst_valid_o, 1'b0);
    tick();
    @(negedge clk);
    check1("c2_valid", inst_valid_o, 1'b1);
    check("c2_addr", inst_addr_o, RPC);

    // Backpressure: buffer fills, requests stop, head holds.
    repeat (10) tick();
    @(negedge clk);
    check1("bp_req", imem_req_o, 1'b0);
    check1("bp_valid", inst_valid_o, 1'b1);
    check("bp_addr", inst_addr_o, RPC);
    check("bp_inflight", 32'(mem_q.size()), 32'd0);
    tick();
    inst_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check1("stream_valid", inst_valid_o, 1'b1);
      tick();
    end

    // Redirect with two stale responses outstanding (latency 3).
    lat = 3;
    repeat (12) tick();
    wait_cond(0, "pre_jump_inflight2");
    do_jump(32'h0000_2003, 1'b0);
    repeat (16) tick();

    // Redirect coincident with a response and a pop (latency 1).
    lat = 1;
    repeat (8) tick();
    wait_cond(1, "pre_jump_rsp_pop");
    do_jump(32'h0000_3000, 1'b1);
    repeat (6) tick();

    // Address wrap.
    wait_cond(1, "pre_wrap_rsp_pop");
    do_jump(32'hFFFF_FFF8, 1'b1);
    repeat (8) tick();

    // Async reset with two fetches in flight.
    lat = 3;
    repeat (10) tick();
    wait_cond(0, "pre_reset_inflight2");
    #1;
    rst = 1'b0;
    #1;
    check_reset_outputs("arst");
    tick();
    tick();
    rst = 1'b1;
    #1;
    check1("rel_req", imem_req_o, 1'b1);
    check("rel_addr", imem_addr_o, RPC);
    repeat (12) tick();

    // Randomized run: latency, grants, ready, redirects and spurious responses.
    spur_en = 1'b1;
    gnt_pct = 70;
    repeat (3000) begin
      tick();
      if ($urandom_range(0, 15) == 0) lat = $urandom_range(1, 4);
      inst_ready_i = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 99) < 4) begin
        jump_flag_i = 1'b1;
        jump_addr_i = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : $urandom;
      end else begin
        jump_flag_i = 1'b0;
      end
    end
    tick();
    jump_flag_i  = 1'b0;
    inst_ready_i = 1'b1;
    gnt_pct      = 100;
    spur_en      = 1'b0;
    repeat (20) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
